// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad-to-combination-lock controller.
//   Serializes accepted keys into one-cycle Enter/Digit strobes, samples the
//   lock's active-low Open/Fail indications, holds the lock open for
//   OPEN_CYCLES, then relocks it through the lock's synchronous reset.
//   Counts consecutive failures, pulses Alarm on reaching MAX_FAILS.
//   Optional feature macro: LOCK_SEQ_LOCKOUT_EN enables the timed LOCKOUT
//   state (LOCKOUT_CYCLES) and the locked_out_o output; without it
//   locked_out_o is tied low and FailCount saturates.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   key_valid_i/key_code_i   key strobe + code (taken only while key_ready_o)
//   cancel_i                 abandon a one-digit partial entry
//   key_ready_o              controller accepts a key this cycle
//   lock_enter_o/lock_digit_o  Enter strobe and digit to the lock
//   lock_reset_o             active-high sync reset to the lock
//   lock_open_ni/lock_fail_ni  lock indications, active-low
//   unlocked_o, locked_out_o, alarm_o, fail_count_o, ctrl_state_o  status
module lock_sequencer #(
  parameter int unsigned OPEN_CYCLES    = 16,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 64,
  parameter int unsigned TIMER_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       cancel_i,
  output logic       key_ready_o,
  output logic       lock_enter_o,
  output logic [3:0] lock_digit_o,
  output logic       lock_reset_o,
  input  logic       lock_open_ni,
  input  logic       lock_fail_ni,
  output logic       unlocked_o,
  output logic       locked_out_o,
  output logic       alarm_o,
  output logic [2:0] fail_count_o,
  output logic [2:0] ctrl_state_o
);

  typedef enum logic [2:0] {
    S_CLEAR     = 3'd0,
    S_ARMED     = 3'd1,
    S_PULSE     = 3'd2,
    S_CHECK     = 3'd3,
    S_OPEN_HOLD = 3'd4,
    S_FAIL_HOLD = 3'd5,
    S_LOCKOUT   = 3'd6,
    S_UNUSED    = 3'd7
  } state_e;

  // Timers count down from N-1 to 0 so the hold lasts exactly N cycles.
  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]         MAX_F     = 3'(MAX_FAILS);

  state_e             state_q, state_d;
  logic [1:0]         digit_cnt_q, digit_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         fail_q, fail_d;
  logic [3:0]         lock_digit_q, lock_digit_d;
  logic               alarm_q, alarm_d;
  logic               key_ready_q, lock_enter_q, lock_reset_q;
  logic               unlocked_q, locked_out_q;

  always_comb begin
    state_d      = state_q;
    digit_cnt_d  = digit_cnt_q;
    timer_d      = timer_q;
    fail_d       = fail_q;
    lock_digit_d = lock_digit_q;
    alarm_d      = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        digit_cnt_d = 2'd0;
        state_d     = S_ARMED;
      end
      S_ARMED: begin
        if (key_valid_i) begin
          lock_digit_d = key_code_i;
          digit_cnt_d  = digit_cnt_q + 2'd1;
          state_d      = S_PULSE;
        end else if (cancel_i && digit_cnt_q == 2'd1) begin
          state_d = S_CLEAR;
        end
      end
      S_PULSE: state_d = S_CHECK;
      S_CHECK: begin
        if (!lock_open_ni) begin
          fail_d  = 3'd0;
          timer_d = OPEN_LOAD;
          state_d = S_OPEN_HOLD;
        end else if (!lock_fail_ni || digit_cnt_q == 2'd2) begin
          // Count updates on entry so FAIL_HOLD and Alarm see the new value.
          if (fail_q != MAX_F) fail_d = fail_q + 3'd1;
          // Alarm only on the transition into MAX, never while saturated.
          alarm_d = (fail_q == MAX_F - 3'd1);
          state_d = S_FAIL_HOLD;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_OPEN_HOLD: begin
        if (timer_q == '0) state_d = S_CLEAR;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      S_FAIL_HOLD: begin
        // Preload is ignored by CLEAR when no lockout follows.
        timer_d = LOCK_LOAD;
`ifdef LOCK_SEQ_LOCKOUT_EN
        state_d = alarm_q ? S_LOCKOUT : S_CLEAR;
`else
        state_d = S_CLEAR;
`endif
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d  = 3'd0;
          state_d = S_CLEAR;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with
  // state_q without a decode stage on the output path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_CLEAR;
      digit_cnt_q  <= 2'd0;
      timer_q      <= '0;
      fail_q       <= 3'd0;
      lock_digit_q <= 4'd0;
      alarm_q      <= 1'b0;
      key_ready_q  <= 1'b0;
      lock_enter_q <= 1'b0;
      lock_reset_q <= 1'b1;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_cnt_q  <= digit_cnt_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      lock_digit_q <= lock_digit_d;
      alarm_q      <= alarm_d;
      key_ready_q  <= (state_d == S_ARMED);
      lock_enter_q <= (state_d == S_PULSE);
      lock_reset_q <= (state_d == S_CLEAR) || (state_d == S_LOCKOUT);
      unlocked_q   <= (state_d == S_OPEN_HOLD);
`ifdef LOCK_SEQ_LOCKOUT_EN
      locked_out_q <= (state_d == S_LOCKOUT);
`else
      locked_out_q <= 1'b0;
`endif
    end
  end

  assign key_ready_o  = key_ready_q;
  assign lock_enter_o = lock_enter_q;
  assign lock_digit_o = lock_digit_q;
  assign lock_reset_o = lock_reset_q;
  assign unlocked_o   = unlocked_q;
  assign locked_out_o = locked_out_q;
  assign alarm_o      = alarm_q;
  assign fail_count_o = fail_q;
  assign ctrl_state_o = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: a two-digit lock stub (code 2,3) answers the
// controller; attempts are checked against a transaction-level model of the
// failure count, alarm, lockout and hold lengths.
module tb_lock_sequencer;
  localparam int OPEN_C = 16;
  localparam int MAXF   = 3;
  localparam int LOCK_C = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic cancel = 1'b0;
  logic key_ready, lock_enter, lock_reset, unlocked, locked_out, alarm;
  logic [3:0] lock_digit;
  logic [2:0] fail_count, state;
  logic s_open_n = 1'b1, s_fail_n = 1'b1;
  logic [1:0] s_n = 2'd0;
  logic [3:0] s_d0 = 4'd0;
  bit stub_mute = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int enter_cnt = 0;
  int m_fail = 0;

  always #5 clk = ~clk;

  lock_sequencer #(.OPEN_CYCLES(OPEN_C), .MAX_FAILS(MAXF),
                   .LOCKOUT_CYCLES(LOCK_C), .TIMER_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .key_valid_i(key_valid), .key_code_i(key_code),
    .cancel_i(cancel), .key_ready_o(key_ready), .lock_enter_o(lock_enter),
    .lock_digit_o(lock_digit), .lock_reset_o(lock_reset),
    .lock_open_ni(s_open_n), .lock_fail_ni(s_fail_n), .unlocked_o(unlocked),
    .locked_out_o(locked_out), .alarm_o(alarm), .fail_count_o(fail_count),
    .ctrl_state_o(state));

  // Lock stub: decides on the second digit; muted stub never signals fail,
  // so the controller must fail on its own digit count.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lock_enter) enter_cnt <= enter_cnt + 1;
    if (lock_reset) begin
      s_n <= 2'd0; s_open_n <= 1'b1; s_fail_n <= 1'b1;
    end else if (lock_enter) begin
      if (s_n == 2'd0) begin
        s_d0 <= lock_digit; s_n <= 2'd1;
      end else begin
        s_n <= 2'd2;
        if (s_d0 == 4'd2 && lock_digit == 4'd3) s_open_n <= 1'b0;
        else if (!stub_mute) s_fail_n <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d, input bit with_cancel);
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 300) begin step(); n++; end
    chk("ready_wait", key_ready, 1);
    key_valid = 1'b1; key_code = d; cancel = with_cancel;
    step();
    key_valid = 1'b0; cancel = 1'b0;
    chk("enter_on_key", lock_enter, 1);
    chk("digit_reg", lock_digit, d);
    chk("ready_low", key_ready, 0);
  endtask

  // Two steps through PULSE/CHECK, optionally with junk key/cancel activity.
  task automatic settle(input logic [3:0] d, input bit noise);
    key_valid = noise; cancel = noise; key_code = ~d;
    step(); step();
    key_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic attempt(input logic [3:0] d1, input logic [3:0] d2,
                         input bit mute, input bit noise, input bit cfirst);
    int t0, e0, n;
    bit exp_alarm;
    stub_mute = mute;
    e0 = enter_cnt;
    press(d1, cfirst);
    t0 = cyc;
    settle(d1, noise);
    chk("digit_hold", lock_digit, d1);
    chk("armed_between", state, 1);
    press(d2, 1'b0);
    settle(d2, noise);
    chk("enters_per_attempt", enter_cnt - e0, 2);
    if (d1 == 4'd2 && d2 == 4'd3) begin
      m_fail = 0;
      chk("open_latency", cyc - t0, 5);
      chk("unlocked", unlocked, 1);
      chk("fail_clr_open", fail_count, m_fail);
      n = 0;
      while (unlocked === 1'b1 && n < 200) begin
        n++; key_valid = noise; key_code = 4'd9; step();
      end
      key_valid = 1'b0;
      chk("open_len", n, OPEN_C);
      chk("no_enter_in_open", enter_cnt - e0, 2);
      chk("relock_reset", lock_reset, 1);
      chk("relock_state", state, 0);
    end else begin
      exp_alarm = (m_fail == MAXF - 1);
      if (m_fail < MAXF) m_fail++;
      chk("fail_state", state, 5);
      chk("fail_count", fail_count, m_fail);
      chk("alarm", alarm, exp_alarm);
      step();
      chk("alarm_one_cycle", alarm, 0);
`ifdef LOCK_SEQ_LOCKOUT_EN
      if (exp_alarm) begin
        chk("lockout_ready", key_ready, 0);
        chk("lockout_reset", lock_reset, 1);
        n = 0;
        while (locked_out === 1'b1 && n < 300) begin
          n++; key_valid = noise; step();
        end
        key_valid = 1'b0;
        chk("lockout_len", n, LOCK_C);
        m_fail = 0;
        chk("fail_after_lockout", fail_count, m_fail);
      end
`endif
      chk("no_lockout_out", locked_out, 0);
      chk("fail_to_clear", state, 0);
      chk("fail_reset_pulse", lock_reset, 1);
    end
    step();
    chk("back_armed", state, 1);
    chk("armed_ready", key_ready, 1);
    chk("armed_no_reset", lock_reset, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_lreset"}, lock_reset, 1);
    chk({tag, "_digit"}, lock_digit, 0);
    chk({tag, "_fail"}, fail_count, 0);
    chk({tag, "_outs"}, {key_ready, lock_enter, unlocked, locked_out, alarm}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a, b;
    step();
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    step(); step();
    chk_reset_vals("reset_held");
    rst_n = 1'b1;
    step();
    chk("release_armed", state, 1);
    chk("release_ready", key_ready, 1);

    // Cancel with no digits is ignored.
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("cancel_cnt0", state, 1);

    attempt(4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) attempt(4'd5, 4'd3, 1'b0, 1'b0, 1'b0);
    attempt(4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("fail_cleared", fail_count, 0);

    // One failure, then cancel after one digit leaves the count alone.
    attempt(4'd5, 4'd3, 1'b1, 1'b0, 1'b0);
    press(4'd2, 1'b0); settle(4'd2, 1'b0);
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("cancel_clear", state, 0);
    chk("cancel_reset", lock_reset, 1);
    chk("cancel_keeps_fail", fail_count, m_fail);
    step();
    chk("cancel_armed", state, 1);
    // Key beats a simultaneous cancel; noise during PULSE/CHECK/OPEN_HOLD.
    attempt(4'd2, 4'd3, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of OPEN_HOLD.
    press(4'd2, 1'b0); settle(4'd2, 1'b0); press(4'd3, 1'b0); settle(4'd3, 1'b0);
    step(); step(); step();
    chk("pre_reset_open", unlocked, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_open");
    step();
    rst_n = 1'b1; m_fail = 0;
    step();
    chk("rst_open_recover", state, 1);

    // Drive failures up to MAX-1, then reset during the lockout / fail path.
    while (m_fail < MAXF - 1) attempt(4'd7, 4'd1, 1'b0, 1'b0, 1'b0);
    press(4'd7, 1'b0); settle(4'd7, 1'b0); press(4'd1, 1'b0); settle(4'd1, 1'b0);
    chk("pre_reset_alarm", alarm, 1);
`ifdef LOCK_SEQ_LOCKOUT_EN
    step(); step(); step(); step(); step();
    chk("pre_reset_lockout", locked_out, 1);
`endif
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_lockout");
    step();
    rst_n = 1'b1; m_fail = 0;
    step();
    chk("rst_lockout_recover", state, 1);

    // Randomized attempts against the model.
    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
      attempt(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
